// File: rtl/inst_fetch_if.sv
// Instruction-memory read port shared by the fetch unit (master) and the
// instruction memory (slave). Read data returns one cycle after the
// address/enable pair is sampled.
interface inst_fetch_if;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic [15:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage. It keeps one read outstanding to a synchronous
// instruction memory and presents {pc, inst} to decode. A one-entry skid
// buffer keeps a returning word while decode stalls, so no instruction is
// lost or repeated. Jumps and branches redirect the fetch stream, and a HALT
// opcode drains the pipe until do_halt freezes the block.
module inst_fetch (
    input  logic         clk,
    input  logic         rst,            // asynchronous, active-low
    inst_fetch_if.master imem,
    input  logic         stall,
    input  logic         do_jump,
    input  logic [15:0]  jump_address,
    input  logic         do_branch,
    input  logic [15:0]  branch_target,
    input  logic         do_halt,
    output logic [31:0]  to_inst,
    output logic [15:0]  fetch_count,
    output logic         halted
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        DRAIN,
        HALTED
    } state_t;

    // Address of the read that is currently in the memory pipe.
    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
    } inflight_t;

    // Returned word parked while decode is stalled.
    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [15:0] inst;
    } skid_t;

    state_t      state;
    logic [15:0] pc_q;
    inflight_t   inflight;
    skid_t       skid;

    logic        redirect;
    logic [15:0] target;
    logic        next_valid;
    logic [15:0] next_pc;
    logic [15:0] next_word;
    logic        next_is_halt;
    logic        next_counts;

    assign imem.imem_addr = pc_q;
    assign imem.imem_en   = (state == FILL) || (state == RUN);

    // Redirect request and its target; a branch outranks a jump.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        redirect = do_branch || do_jump;
        target   = jump_address;
        if (do_branch) begin
            target = branch_target;
        end
    end

    // Word that decode receives on the next unstalled edge: the skid entry
    // is older than the in-flight read, so it always goes first.
    always_comb begin
        next_valid = 1'b0;
        next_pc    = pc_q;
        next_word  = 16'h0000;
        if (skid.valid) begin
            next_valid = 1'b1;
            next_pc    = skid.pc;
            next_word  = skid.inst;
        end else if (inflight.valid) begin
            next_valid = 1'b1;
            next_pc    = inflight.pc;
            next_word  = imem.imem_rdata;
        end
        next_is_halt = next_valid && (next_word[15:12] == OP_HALT);
        next_counts  = next_valid && (next_word[15:12] != OP_NOP);
    end

    // Fetch FSM with the pc, in-flight tag, skid buffer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst) begin
            state       <= FILL;
            pc_q        <= 16'h0000;
            inflight    <= '0;
            skid        <= '0;
            to_inst     <= 32'h0000_0000;
            fetch_count <= 16'h0000;
            halted      <= 1'b0;
        end else if (state == HALTED) begin
            // Frozen until reset: redirects and stall have no effect.
            halted <= 1'b1;
        end else if (do_halt) begin
            state          <= HALTED;
            halted         <= 1'b1;
            inflight.valid <= 1'b0;
            skid.valid     <= 1'b0;
            to_inst        <= {pc_q, 16'h0000};
        end else if (redirect) begin
            // A redirect wins over stall: decode is told about the new stream at once.
            state          <= FILL;
            pc_q           <= target;
            inflight.valid <= 1'b0;
            skid.valid     <= 1'b0;
            to_inst        <= {target, 16'h0000};
        end else begin
            case (state)
                FILL: begin
                    inflight.valid <= 1'b1;
                    inflight.pc    <= pc_q;
                    pc_q           <= pc_q + 16'd1;
                    to_inst        <= {pc_q, 16'h0000};
                    state          <= RUN;
                end
                RUN: begin
                    if (stall) begin
                        // Park the returning word; pc_q and to_inst hold.
                        if (inflight.valid) begin
                            skid.valid     <= 1'b1;
                            skid.pc        <= inflight.pc;
                            skid.inst      <= imem.imem_rdata;
                            inflight.valid <= 1'b0;
                        end
                    end else begin
                        to_inst    <= {next_pc, next_word};
                        skid.valid <= 1'b0;
                        if (next_counts) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                        if (next_is_halt) begin
                            // Stop issuing reads once a HALT reaches decode.
                            inflight.valid <= 1'b0;
                            state          <= DRAIN;
                        end else begin
                            inflight.valid <= 1'b1;
                            inflight.pc    <= pc_q;
                            pc_q           <= pc_q + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        to_inst <= {pc_q, 16'h0000};
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by a
// randomized stall/redirect run compared against a stream-level model.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        do_jump;
    logic [15:0] jump_address;
    logic        do_branch;
    logic [15:0] branch_target;
    logic        do_halt;
    logic [31:0] to_inst;
    logic [15:0] fetch_count;
    logic        halted;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .stall         (stall),
        .do_jump       (do_jump),
        .jump_address  (jump_address),
        .do_branch     (do_branch),
        .branch_target (branch_target),
        .do_halt       (do_halt),
        .to_inst       (to_inst),
        .fetch_count   (fetch_count),
        .halted        (halted)
    );

    // Synchronous instruction memory: data one cycle after the sampled address.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.imem_en) begin
            bus.imem_rdata <= mem[bus.imem_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        do_jump       = 1'b0;
        do_branch     = 1'b0;
        do_halt       = 1'b0;
        jump_address  = 16'h0000;
        branch_target = 16'h0000;
    endtask

    // Stream-level reference: decode sees base, base+1, ... advancing on every
    // unstalled edge after a one-edge fill; a redirect restarts the stream.
    logic [15:0] m_base;
    int          m_d;
    bit          m_fill;
    logic [15:0] m_count;
    logic [15:0] m_pc;
    logic [15:0] w;
    int          r;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = {4'h1, 12'(i)};
        end
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_to_inst", to_inst, 32'h0);
        check("rst_count", {16'h0, fetch_count}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_addr", {16'h0, bus.imem_addr}, 32'h0);
        check("rst_en", {31'h0, bus.imem_en}, 32'h1);

        // Straight line: pcs 0..3 from the second edge after release
        rst = 1'b1;
        tick();
        check("line_fill_nop", to_inst, 32'h0);
        check("line_fill_addr", {16'h0, bus.imem_addr}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("line_inst", to_inst, {16'(i), mem[i]});
        end
        check("line_count", {16'h0, fetch_count}, 32'd4);

        // Stall while pc 5 is in flight
        tick();
        check("stall_pre", to_inst, {16'd4, mem[4]});
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", to_inst, {16'd4, mem[4]});
        end
        stall = 1'b0;
        for (int i = 5; i < 8; i++) begin
            tick();
            check("stall_release", to_inst, {16'(i), mem[i]});
        end
        check("stall_count", {16'h0, fetch_count}, 32'd8);

        // Redirect: branch beats jump, stall on the redirect edge is ignored
        do_branch     = 1'b1;
        branch_target = 16'h0040;
        do_jump       = 1'b1;
        jump_address  = 16'h0080;
        stall         = 1'b1;
        tick();
        clear_inputs();
        check("redir_nop", to_inst, {16'h0040, 16'h0000});
        check("redir_addr", {16'h0, bus.imem_addr}, 32'h0040);
        tick();
        check("redir_fill", to_inst, {16'h0040, 16'h0000});
        tick();
        check("redir_pc40", to_inst, {16'h0040, mem[16'h0040]});
        tick();
        check("redir_pc41", to_inst, {16'h0041, mem[16'h0041]});
        check("redir_count", {16'h0, fetch_count}, 32'd10);

        // Asynchronous reset mid-stream, no clock edge needed
        rst = 1'b0;
        #1;
        check("arst_to_inst", to_inst, 32'h0);
        check("arst_count", {16'h0, fetch_count}, 32'h0);
        check("arst_addr", {16'h0, bus.imem_addr}, 32'h0);

        // Halt: HALT word at pc 3
        mem[3] = 16'hF000;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_stream", to_inst, {16'(i), mem[i]});
        end
        check("halt_en_off", {31'h0, bus.imem_en}, 32'h0);
        check("halt_count", {16'h0, fetch_count}, 32'd4);
        tick();
        check("drain_nop", {16'h0, to_inst[15:0]}, 32'h0);
        check("drain_halted", {31'h0, halted}, 32'h0);
        do_halt = 1'b1;
        tick();
        do_halt = 1'b0;
        check("halted_set", {31'h0, halted}, 32'h1);
        check("halted_en", {31'h0, bus.imem_en}, 32'h0);
        do_branch     = 1'b1;
        branch_target = 16'h0100;
        do_jump       = 1'b1;
        jump_address  = 16'h0200;
        stall         = 1'b1;
        tick();
        clear_inputs();
        tick();
        check("halted_keep", {31'h0, halted}, 32'h1);
        check("halted_no_redir", {31'h0, to_inst[31:16] == 16'h0100}, 32'h0);
        check("halted_inst_nop", {16'h0, to_inst[15:0]}, 32'h0);
        check("halted_en_keep", {31'h0, bus.imem_en}, 32'h0);
        check("halted_count", {16'h0, fetch_count}, 32'd4);

        // Reset in HALTED
        rst = 1'b0;
        #1;
        check("hrst_halted", {31'h0, halted}, 32'h0);
        check("hrst_to_inst", to_inst, 32'h0);
        tick();
        rst = 1'b1;

        // Halt cancel: branch while draining
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("cancel_halt_word", to_inst, {16'd3, 16'hF000});
        do_branch     = 1'b1;
        branch_target = 16'h0020;
        tick();
        clear_inputs();
        check("cancel_nop", to_inst, {16'h0020, 16'h0000});
        check("cancel_en", {31'h0, bus.imem_en}, 32'h1);
        tick();
        tick();
        check("cancel_pc20", to_inst, {16'h0020, mem[16'h0020]});
        tick();
        check("cancel_pc21", to_inst, {16'h0021, mem[16'h0021]});
        check("cancel_halted", {31'h0, halted}, 32'h0);
        check("cancel_count", {16'h0, fetch_count}, 32'd6);

        // Wrap through 16'hFFFF
        do_jump      = 1'b1;
        jump_address = 16'hFFFE;
        tick();
        clear_inputs();
        check("wrap_nop", to_inst, {16'hFFFE, 16'h0000});
        tick();
        check("wrap_fill_addr", {16'h0, bus.imem_addr}, 32'hFFFF);
        tick();
        check("wrap_fffe", to_inst, {16'hFFFE, mem[16'hFFFE]});
        tick();
        check("wrap_ffff", to_inst, {16'hFFFF, mem[16'hFFFF]});
        tick();
        check("wrap_0000", to_inst, {16'h0000, mem[0]});
        rst = 1'b0;
        #1;
        check("wrap_rst_addr", {16'h0, bus.imem_addr}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("wrap_rst_nop", to_inst, 32'h0);
        tick();
        check("wrap_rst_pc0", to_inst, {16'h0000, mem[0]});

        // Randomized stalls and redirects against the stream model
        for (int i = 0; i < 1024; i++) begin
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 14));
            mem[i] = w;
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_base  = 16'h0000;
        m_d     = -1;
        m_fill  = 1'b1;
        m_count = 16'h0000;
        for (int n = 0; n < 400; n++) begin
            r             = int'($urandom_range(0, 15));
            stall         = ($urandom_range(0, 3) == 0);
            do_jump       = (r == 0) || (r == 2);
            do_branch     = (r == 1) || (r == 2);
            jump_address  = 16'($urandom_range(0, 255));
            branch_target = 16'($urandom_range(0, 255));
            if (do_branch || do_jump) begin
                m_base = do_branch ? branch_target : jump_address;
                m_d    = -1;
                m_fill = 1'b1;
            end else if (m_fill) begin
                m_fill = 1'b0;
            end else if (!stall) begin
                m_d++;
                m_pc = m_base + 16'(m_d);
                if (mem[m_pc][15:12] != 4'h0) begin
                    m_count = m_count + 16'd1;
                end
            end
            tick();
            if (m_d < 0) begin
                check("rand_nop", to_inst, {m_base, 16'h0000});
            end else begin
                m_pc = m_base + 16'(m_d);
                check("rand_inst", to_inst, {m_pc, mem[m_pc]});
            end
            check("rand_count", {16'h0, fetch_count}, {16'h0, m_count});
        end
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports:
- clk  in  1  rising-edge clock for all state
- rst  in  1  asynchronous, active-low reset
REQ-002 It SHALL have these ports:
- imem_addr  out  16  instruction memory read address
- imem_en  out  1  instruction memory read enable
- imem_rdata  in  16  read data; valid one cycle after imem_addr/imem_en is sampled
- stall  in  1  data-hazard hold from the decode side
- do_jump  in  1  decode-stage jump request
- jump_address  in  16  jump target
- do_branch  in  1  execute-stage taken-branch request
- branch_target  in  16  branch target
- do_halt  in  1  halt instruction has retired
- to_inst  out  32  Inst packed {pc[31:16], inst[15:0]} to decode
- fetch_count  out  16  count of non-NOP instructions delivered
- halted  out  1  block is in HALTED
REQ-003 Opcode SHALL be inst[15:12]: 4'b0000 is NOP and 4'b1111 is HALT.

Function
REQ-004 Internal state SHALL be:
- pc_q: next fetch address
- inflight: valid bit plus pc of the outstanding read
- skid: a one-entry buffer holding {pc, inst} and a valid bit
- FSM with states FILL, RUN, DRAIN, HALTED
REQ-005 imem_addr SHALL equal pc_q combinationally; imem_en SHALL be 1 in FILL and RUN and 0 in DRAIN and HALTED.
REQ-006 In FILL, the block SHALL set inflight={pc_q,1}, increment pc_q, drive to_inst={pc_q,16'h0000}, and move to RUN next cycle.
REQ-007 In RUN with no stall and no redirect:
- to_inst <= skid if skid is valid (skid then cleared); else {inflight.pc, imem_rdata} if inflight is valid; else a NOP.
- inflight <= {pc_q,1}
- pc_q <= pc_q+1
REQ-008 Fetch-to-to_inst latency SHALL be 2 cycles: address at cycle N, to_inst updates at edge N+1.
REQ-009 Stall SHALL behave as follows:
- to_inst and pc_q hold.
- A valid returning word is captured in skid, and inflight is cleared.
- On release, skid is delivered first with no bubble and no lost or duplicated instruction.
REQ-010 A redirect SHALL do all of the following on the same edge, regardless of stall:
- pc_q <= target
- inflight and skid invalidated
- to_inst <= {target,16'h0000}
- state <= FILL
REQ-011 do_branch SHALL take priority over do_jump.
REQ-012 When the word entering to_inst has opcode 1111, the state SHALL go to DRAIN, with inflight invalid; to_inst then becomes NOP on the next edge.
REQ-013 In DRAIN, a redirect SHALL apply REQ-010 (cancelling the halt), and do_halt SHALL move the state to HALTED.
REQ-014 do_halt SHALL move the state to HALTED from any state, with priority over a redirect.
REQ-015 HALTED SHALL be exited only by reset; in HALTED:
- to_inst = {pc_q,16'h0000}
- pc_q is frozen
- halted = 1
- redirects and stall are ignored
REQ-016 fetch_count SHALL increment by 1 on each edge where a non-NOP word is loaded into to_inst, and SHALL wrap 16'hFFFF->0.
REQ-017 pc_q SHALL wrap 16'hFFFF->16'h0000.
REQ-018 Targets SHALL be taken verbatim; no alignment or sign handling is done in this block.

Reset
REQ-019 While rst=0, asynchronously:
- pc_q = 0, inflight and skid invalid, state = FILL
- to_inst = 32'h0
- fetch_count = 0
- halted = 0
REQ-020 Reset asserted mid-stall, mid-redirect or in HALTED SHALL discard all buffered words; the first fetch after release SHALL be address 0.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Straight line: memory word(i) = 16'h1000|i, rst released at cycle 0 -> to_inst.pc = 0,1,2,3 on consecutive cycles from cycle 2, inst matches, fetch_count = 4.
- Stall: stall held 3 cycles while pc 5 is in flight -> to_inst holds pc 4; after release pcs 5,6,7 follow with no gap or duplicate.
- Redirect: do_branch (target 16'h0040) and do_jump (target 16'h0080) in the same cycle -> NOP, then to_inst.pc = 0x40, 0x41; stall during the redirect cycle is ignored.
- Halt: word 16'hF000 at pc 3 -> imem_en = 0 after its delivery; do_halt 2 cycles later -> halted = 1; subsequent redirects have no effect; fetch_count = 4.
- Halt cancel: a branch arrives in DRAIN -> fetch resumes at the target and halted stays 0.
- Wrap: pc_q preset via jump to 16'hFFFE -> pcs FFFE, FFFF, 0000; rst pulsed mid-stream -> next fetched pc = 0.
